// File: rtl/gift_pkg.sv
// Shared GIFT-128 constants, FSM encoding, inverse S-box table and the
// inverse bit-permutation helper used by the ISE core and its models.
package gift_pkg;

    localparam int STATE_W   = 128;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PERM,
        ST_SBOX,
        ST_DONE
    } gift_state_e;

    // Entry k is SubCells^-1(k); listed from index 15 down to index 0.
    localparam logic [15:0][3:0] INV_SBOX = {
        4'h5, 4'hF, 4'h9, 4'h3, 4'hA, 4'h1, 4'h7, 4'hE,
        4'hB, 4'h4, 4'hC, 4'h2, 4'h6, 4'h8, 4'h0, 4'hD
    };

    // Forward PermBits destination of bit i.
    function automatic int gift_p(input int i);
        return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    function automatic logic [STATE_W-1:0] gift_invperm(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] y;
        y = '0;
        for (int i = 0; i < STATE_W; i++)
            y[i] = x[gift_p(i)];
        return y;
    endfunction

endpackage

// File: rtl/gift_invperm_ise_if.sv
// Word-port bus between the core and the GIFT inverse-permutation ISE.
interface gift_invperm_ise_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/gift_inv_sbox4.sv
// 4-bit combinational GIFT inverse S-box.
module gift_inv_sbox4
    import gift_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);
    assign y = INV_SBOX[x];
endmodule

// File: rtl/gift_invperm_ise.sv
// GIFT-128 PermBits^-1 coprocessor; defining GIFT_INV_SBOX_EN adds a
// word-serial SubCells^-1 pass after the permutation.
module gift_invperm_ise
    import gift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    gift_invperm_ise_if.slave bus
);

    logic [NUM_WORDS-1:0][WORD_W-1:0] st;
    gift_state_e                      fsm;
    logic                             busy_q;
    logic                             done_q;

`ifdef GIFT_INV_SBOX_EN
    logic [1:0]        cnt;
    logic [WORD_W-1:0] sbox_out;
    logic [WORD_W-1:0] sel_word;

    assign sel_word = st[cnt];

    for (genvar n = 0; n < 8; n++) begin : g_sbox
        gift_inv_sbox4 u_sbox (
            .x (sel_word[4*n +: 4]),
            .y (sbox_out[4*n +: 4])
        );
    end
`endif

    assign bus.rd_data = st[bus.rd_addr];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= '0;
            fsm    <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef GIFT_INV_SBOX_EN
            cnt    <= 2'd0;
`endif
        end else begin
            case (fsm)
                ST_IDLE: begin
                    // A write coinciding with start lands first, so the op sees it.
                    if (bus.wr_en)
                        st[bus.wr_addr] <= bus.wr_data;
                    if (bus.start) begin
                        fsm    <= ST_PERM;
                        busy_q <= 1'b1;
                    end
                end
                ST_PERM: begin
                    st <= gift_invperm(st);
`ifdef GIFT_INV_SBOX_EN
                    fsm    <= ST_SBOX;
`else
                    fsm    <= ST_DONE;
                    done_q <= 1'b1;
`endif
                end
`ifdef GIFT_INV_SBOX_EN
                ST_SBOX: begin
                    st[cnt] <= sbox_out;
                    if (cnt == 2'd3) begin
                        cnt    <= 2'd0;
                        fsm    <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
`endif
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    fsm    <= ST_IDLE;
                end
                default: begin
                    fsm    <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gift_invperm_ise.sv
// Directed + randomized bench for gift_invperm_ise; honours GIFT_INV_SBOX_EN.
module tb_gift_invperm_ise;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    gift_invperm_ise_if bus ();

    gift_invperm_ise dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef GIFT_INV_SBOX_EN
    localparam int EXP_EDGES = 6;
`else
    localparam int EXP_EDGES = 2;
`endif

    int sb_tab [16] = '{13, 0, 8, 6, 2, 12, 4, 11, 14, 7, 1, 10, 3, 9, 15, 5};

    // Bit i travels to position pmap(i) in the forward permutation.
    function automatic int pmap(input int i);
        int seg, grp, b;
        seg = i >> 4;
        grp = (i >> 2) & 3;
        b   = i & 3;
        return seg * 4 + ((grp * 3 + b) & 3) * 32 + b;
    endfunction

    function automatic logic [127:0] fwd_perm(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 128; i++) y[pmap(i)] = x[i];
        return y;
    endfunction

    function automatic logic [127:0] inv_perm(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 128; i++) y[i] = x[pmap(i)];
        return y;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) y[4*k +: 4] = 4'(sb_tab[int'(x[4*k +: 4])]);
        return y;
    endfunction

    function automatic logic [127:0] ref_op(input logic [127:0] x);
`ifdef GIFT_INV_SBOX_EN
        return inv_sub(inv_perm(x));
`else
        return inv_perm(x);
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_state(output logic [127:0] s);
        s = '0;
        for (int w = 0; w < 4; w++) begin
            bus.rd_addr = 2'(w);
            #1;
            s[32*w +: 32] = bus.rd_data;
        end
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Loads x, starts (optionally writing word 3 in the start cycle), waits for done.
    task automatic run_op(input logic [127:0] x, input bit merge, output logic [127:0] res,
                          output int edges);
        bit busy_ok, got;
        for (int w = 0; w < (merge ? 3 : 4); w++) write_word(w, x[32*w +: 32]);
        if (merge) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 2'd3;
            bus.wr_data = x[127:96];
        end
        bus.start = 1'b1;
        busy_ok = 1'b1;
        got = 1'b0;
        edges = 0;
        while (!got && edges < 20) begin
            tick();
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            edges++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) got = 1'b1;
        end
        chk("busy_during_op", 128'(busy_ok), 128'd1);
        tick();
        chk("done_one_cycle", 128'(bus.done), 128'd0);
        chk("busy_back_idle", 128'(bus.busy), 128'd0);
        read_state(res);
    endtask

    logic [127:0] x, res, expv;
    int           edges;
    bit           seen_done;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 32'd0;
        bus.start = 1'b0;
        bus.rd_addr = 2'd0;
        #3;
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_done", 128'(bus.done), 128'd0);
        for (int w = 0; w < 4; w++) begin
            bus.rd_addr = 2'(w);
            #1;
            chk($sformatf("reset_word%0d", w), 128'(bus.rd_data), 128'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single-bit directed cases.
        x = 128'h2 << 32;
        run_op(x, 1'b0, res, edges);
        chk("edges_bit33", 128'(edges), 128'(EXP_EDGES));
        chk("bit33_model", res, ref_op(x));
`ifndef GIFT_INV_SBOX_EN
        chk("bit33_const", res, 128'h2);
`endif
        x = 128'h8000_0000 << 96;
        run_op(x, 1'b0, res, edges);
        chk("bit127_model", res, ref_op(x));
`ifndef GIFT_INV_SBOX_EN
        chk("bit127_const", res, 128'h0008_0000 << 96);
`endif
        x = 128'h1 << 96;
        run_op(x, 1'b0, res, edges);
        chk("bit96_model", res, ref_op(x));
`ifndef GIFT_INV_SBOX_EN
        chk("bit96_const", res, 128'h10);
`endif
        run_op(128'd0, 1'b0, res, edges);
`ifdef GIFT_INV_SBOX_EN
        chk("zero_all_d", res, {4{32'hDDDD_DDDD}});
`else
        chk("zero_stays", res, 128'd0);
`endif

        // Round trip through the forward permutation.
        for (int t = 0; t < 16; t++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run_op(fwd_perm(x), 1'b0, res, edges);
`ifdef GIFT_INV_SBOX_EN
            expv = inv_sub(x);
`else
            expv = x;
`endif
            chk($sformatf("roundtrip%0d", t), res, expv);
            chk($sformatf("edges%0d", t), 128'(edges), 128'(EXP_EDGES));
        end

        // Write and start in the same cycle.
        x = {$urandom, $urandom, $urandom, $urandom};
        run_op(x, 1'b1, res, edges);
        chk("write_with_start", res, ref_op(x));

        // Writes and start held while busy, including the DONE cycle.
        x = {$urandom, $urandom, $urandom, $urandom};
        for (int w = 0; w < 4; w++) write_word(w, x[32*w +: 32]);
        bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b1;
        bus.wr_data = 32'hFFFF_FFFF;
        seen_done = 1'b0;
        for (int n = 0; n < 20 && !seen_done; n++) begin
            bus.wr_addr = 2'(n);
            tick();
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("busy_ignore_done_seen", 128'(seen_done), 128'd1);
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("busy_ignore_idle", 128'(bus.busy), 128'd0);
        read_state(res);
        chk("busy_ignore_state", res, ref_op(x));
        tick();
        chk("no_restart", 128'(bus.busy), 128'd0);

        // Abort by reset at two points inside the operation.
        for (int p = 0; p < 2; p++) begin
            x = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            for (int w = 0; w < 4; w++) write_word(w, x[32*w +: 32]);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int n = 1; n < (p == 0 ? 1 : EXP_EDGES - 1); n++) tick();
            rst_n = 1'b0;
            #1;
            read_state(res);
            chk($sformatf("abort%0d_state", p), res, 128'd0);
            chk($sformatf("abort%0d_busy", p), 128'(bus.busy), 128'd0);
            tick();
            rst_n = 1'b1;
            seen_done = 1'b0;
            for (int n = 0; n < 8; n++) begin
                tick();
                if (bus.done !== 1'b0) seen_done = 1'b1;
            end
            chk($sformatf("abort%0d_no_done", p), 128'(seen_done), 128'd0);
            run_op(x, 1'b0, res, edges);
            chk($sformatf("abort%0d_recover", p), res, ref_op(x));
            chk($sformatf("abort%0d_edges", p), 128'(edges), 128'(EXP_EDGES));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
